// File: rtl/io_pkg.sv
// ---------------------------------------------------------------------------
// io_pkg -- shared definitions for the io_responder data-memory responder.
//   * access size encodings driven by the core's M stage
//   * word offsets of the memory-mapped I/O registers (address[3:2])
//   * STATUS register bit positions
//   * serial transmitter state encoding and the idle line level
//   * load_extend(): lane selection plus sign/zero extension for loads
// Related build macro (used in io_responder): IO_CYCLE_COUNTER_EN.
// ---------------------------------------------------------------------------
package io_pkg;

    // access_size encodings; 2'd3 is treated as a word access
    localparam logic [1:0] ACC_BYTE = 2'd0;
    localparam logic [1:0] ACC_HALF = 2'd1;
    localparam logic [1:0] ACC_WORD = 2'd2;

    // I/O register word offsets inside the 16-byte window
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CYCLE  = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    // STATUS layout: {24'b0, count[4:0], overflow, full, empty}
    localparam int ST_EMPTY_BIT = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_OVF_BIT   = 2;
    localparam int ST_COUNT_LSB = 3;
    localparam int ST_COUNT_W   = 5;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;

    // Right-justify the addressed lane of a 32-bit word and extend it.
    // Half accesses use address[1] only; word accesses ignore the lane.
    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            ACC_BYTE: r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            ACC_HALF: r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            ACC_WORD: r = word;
            default:  r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/io_uart_tx.sv
// ---------------------------------------------------------------------------
// io_uart_tx -- console transmit path: byte FIFO, baud divisor register,
// bit timer and 8N1 shifter.
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   push_valid/push_data enqueue request (dropped and flagged when full)
//   baud_wr/baud_wdata  load a new divisor (used from the next bit boundary)
//   clr_overflow        clear the sticky overflow flag
//   count/full/empty/overflow  FIFO status
//   baud_div            current divisor register value
//   tx_out              serial line, idle high
//   tx_busy             shifter active or FIFO non-empty
// ---------------------------------------------------------------------------
module io_uart_tx
    import io_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] BAUD_RESET = 16'd867,
    localparam int         PW         = $clog2(FIFO_DEPTH),
    localparam int         CW         = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_valid,
    input  logic [7:0]    push_data,
    input  logic          baud_wr,
    input  logic [15:0]   baud_wdata,
    input  logic          clr_overflow,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic [15:0]   baud_div,
    output logic          tx_out,
    output logic          tx_busy
);

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   baud_div_q, baud_div_d;
    tx_state_t     state_q, state_d;
    logic [15:0]   timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_out_q, tx_out_d;
    logic          tx_busy_q, tx_busy_d;
    logic          push_ok;
    logic          pop;

    // full/empty come from the pre-edge count, so a push into a full FIFO
    // is dropped even when the shifter pops in the same cycle
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        push_ok    = push_valid && !full;
        pop        = 1'b0;
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        tx_out_d   = tx_out_q;

        // timer counts down from the divisor; 0 marks the last clock of a
        // bit. Reloading from baud_div_q at each boundary is what makes a
        // divisor write take effect only at the next bit.
        case (state_q)
            TX_IDLE: begin
                tx_out_d = LINE_IDLE;
                if (!empty) begin
                    pop      = 1'b1;
                    shreg_d  = fifo_mem[rd_ptr_q];
                    state_d  = TX_START;
                    tx_out_d = 1'b0;
                    timer_d  = baud_div_q;
                end
            end
            TX_START: begin
                if (timer_q == '0) begin
                    state_d   = TX_DATA;
                    bit_idx_d = 3'd0;
                    tx_out_d  = shreg_q[0];
                    timer_d   = baud_div_q;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (timer_q == '0) begin
                    timer_d = baud_div_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d  = TX_STOP;
                        tx_out_d = LINE_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        tx_out_d  = shreg_q[1];
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (timer_q == '0) begin
                    // chain straight into the next frame when one is queued
                    if (!empty) begin
                        pop      = 1'b1;
                        shreg_d  = fifo_mem[rd_ptr_q];
                        state_d  = TX_START;
                        tx_out_d = 1'b0;
                        timer_d  = baud_div_q;
                    end else begin
                        state_d  = TX_IDLE;
                        tx_out_d = LINE_IDLE;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                state_d  = TX_IDLE;
                tx_out_d = LINE_IDLE;
            end
        endcase

        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q;
        if (push_valid && full) begin
            overflow_d = 1'b1;
        end
        if (clr_overflow) begin
            overflow_d = 1'b0;
        end

        baud_div_d = baud_wr ? baud_wdata : baud_div_q;
        tx_busy_d  = (state_d != TX_IDLE) || (count_d != '0);
    end

    // storage is not reset; the pointers alone define the contents
    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= TX_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            tx_out_q   <= LINE_IDLE;
            tx_busy_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            baud_div_q <= BAUD_RESET;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            tx_out_q   <= tx_out_d;
            tx_busy_q  <= tx_busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            baud_div_q <= baud_div_d;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;
    assign baud_div = baud_div_q;
    assign tx_out   = tx_out_q;
    assign tx_busy  = tx_busy_q;

endmodule

// File: rtl/io_responder.sv
// ---------------------------------------------------------------------------
// io_responder -- data-memory responder for the core's M stage. Decodes each
// access to backing RAM or to a 16-byte I/O window (TXDATA, STATUS, CYCLE,
// BAUD). Reads are combinational; writes commit on the rising clock edge.
// Ports:
//   clock, reset     system clock, asynchronous active-high reset
//   address          byte address
//   data_in          store data, right-justified
//   read_write       1 = read, 0 = write
//   access_size      0 byte, 1 half, 2/3 word
//   unsigned_access  1 zero-extends sub-word loads, 0 sign-extends
//   data_out         load data (combinational)
//   tx_out, tx_busy  console serial line and activity flag
// Build macro IO_CYCLE_COUNTER_EN: when defined, CYCLE is a free-running
// 32-bit counter; otherwise no counter exists and CYCLE reads 0.
// ---------------------------------------------------------------------------
module io_responder
    import io_pkg::*;
#(
    parameter int          RAM_WORDS  = 4096,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] BAUD_RESET = 16'd867
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic        read_write,
    input  logic [1:0]  access_size,
    input  logic        unsigned_access,
    output logic [31:0] data_out,
    output logic        tx_out,
    output logic        tx_busy
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram [RAM_WORDS];
    logic          io_sel;
    logic          wr_en;
    logic [AW-1:0] ram_idx;
    logic [1:0]    reg_off;
    logic [3:0]    be;
    logic [31:0]   ram_wdata;
    logic [31:0]   io_rdata;
    logic [31:0]   rd_word;
    logic [31:0]   cycle_val;
    logic [4:0]    status_count;

    logic [CW-1:0] tx_count;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_overflow;
    logic [15:0]   baud_div;

    assign io_sel  = (address[31:4] == IO_BASE[31:4]);
    assign wr_en   = !read_write;
    assign ram_idx = address[AW+1:2];
    assign reg_off = address[3:2];

    // Byte enables and lane-replicated store data: sub-word stores take the
    // low bits of data_in and steer them to the addressed lane(s).
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign be[gi] = (access_size == ACC_BYTE) ? (address[1:0] == 2'(gi)) :
                        (access_size == ACC_HALF) ? (address[1] == 1'(gi >> 1)) :
                        1'b1;
        assign ram_wdata[8*gi +: 8] =
                        (access_size == ACC_BYTE) ? data_in[7:0] :
                        (access_size == ACC_HALF) ? data_in[8*(gi % 2) +: 8] :
                        data_in[8*gi +: 8];
    end

    always_ff @(posedge clock) begin
        if (wr_en && !io_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    ram[ram_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef IO_CYCLE_COUNTER_EN
    logic [31:0] cycle_q, cycle_d;

    assign cycle_d = cycle_q + 32'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    assign cycle_val = cycle_q;
`else
    assign cycle_val = 32'h0;
`endif

    io_uart_tx #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .BAUD_RESET (BAUD_RESET)
    ) u_uart_tx (
        .clock        (clock),
        .reset        (reset),
        .push_valid   (wr_en && io_sel && (reg_off == REG_TXDATA)),
        .push_data    (data_in[7:0]),
        .baud_wr      (wr_en && io_sel && (reg_off == REG_BAUD)),
        .baud_wdata   (data_in[15:0]),
        .clr_overflow (wr_en && io_sel && (reg_off == REG_STATUS)),
        .count        (tx_count),
        .full         (tx_full),
        .empty        (tx_empty),
        .overflow     (tx_overflow),
        .baud_div     (baud_div),
        .tx_out       (tx_out),
        .tx_busy      (tx_busy)
    );

    // STATUS count field is 5 bits wide and saturates for deep FIFOs
    always_comb begin
        if (32'(tx_count) > 32'd31) begin
            status_count = 5'd31;
        end else begin
            status_count = 5'(tx_count);
        end
    end

    always_comb begin
        io_rdata = '0;
        case (reg_off)
            REG_TXDATA: io_rdata = '0;
            REG_STATUS: begin
                io_rdata[ST_EMPTY_BIT]                = tx_empty;
                io_rdata[ST_FULL_BIT]                 = tx_full;
                io_rdata[ST_OVF_BIT]                  = tx_overflow;
                io_rdata[ST_COUNT_LSB +: ST_COUNT_W]  = status_count;
            end
            REG_CYCLE:  io_rdata = cycle_val;
            REG_BAUD:   io_rdata = {16'd0, baud_div};
            default:    io_rdata = '0;
        endcase
    end

    // registers are presented as full words; sub-word loads then go through
    // the same lane select and extension as RAM
    assign rd_word  = io_sel ? io_rdata : ram[ram_idx];
    assign data_out = load_extend(rd_word, access_size, address[1:0], unsigned_access);

endmodule
